pipeline_stage_skid: RTL

Parametrised pipeline stage register for the MIPS datapath, the general replacement for fixed-field inter-stage registers such as IF/ID, ID/EX, EX/MEM and MEM/WB. It carries one control bundle and one data bundle per instruction and supports valid/ready backpressure through a one-entry skid slot. It also takes a hazard-unit stall (freeze) and a branch/jump flush (bubble insertion). It sits between any two pipeline stages and keeps a saturating count of flushed instructions for debug.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/pipe_slot_reg.sv | 28 ++
 rtl/pipeline_stage_skid.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline stage register.
// Holds the state encoding, the default NOP control value and per-stage bundle widths.
// No logic, no timing.
package pipe_pkg;

    // Occupancy of a stage: how many instructions it currently holds.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    // Control value that downstream decodes as a NOP.
    localparam logic [7:0] BUBBLE_CTRL_DEFAULT = 8'h00;

    // Bundle widths used by the four classic MIPS inter-stage registers.
    localparam int IFID_CTRL_W  = 8;
    localparam int IFID_DATA_W  = 64;
    localparam int IDEX_CTRL_W  = 8;
    localparam int IDEX_DATA_W  = 128;
    localparam int EXMEM_CTRL_W = 8;
    localparam int EXMEM_DATA_W = 104;
    localparam int MEMWB_CTRL_W = 8;
    localparam int MEMWB_DATA_W = 72;

endpackage

// File: rtl/pipe_slot_reg.sv
// One instruction slot: a loadable register with synchronous reset value.
// Latency: load value visible one cycle after en.
// Backpressure: none; the owner decides when to load via en.
module pipe_slot_reg #(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] slot_q;

    // Load on enable; reset forces the configured empty value.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q <= RST_VAL;
        end else if (en) begin
            slot_q <= d;
        end
    end

    assign q = slot_q;

endmodule

// File: rtl/pipeline_stage_skid.sv
// Pipeline stage register with a one-entry skid slot, hazard stall and flush.
// Latency: 1 cycle from accept to out_valid; full throughput under out_ready.
// Backpressure: in_ready drops when both slots are occupied or on stall.
module pipeline_stage_skid
    import pipe_pkg::*;
#(
    parameter int                    CTRL_WIDTH  = 8,
    parameter int                    DATA_WIDTH  = 128,
    parameter logic [CTRL_WIDTH-1:0] BUBBLE_CTRL = CTRL_WIDTH'(BUBBLE_CTRL_DEFAULT),
    parameter int                    CNT_WIDTH   = 16   // must be >= 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  stall,
    input  logic                  flush,
    output logic [CNT_WIDTH-1:0]  flush_cnt
);

    localparam int W = CTRL_WIDTH + DATA_WIDTH;

    state_t               state_q, state_d;
    logic                 main_en, skid_en;
    logic [W-1:0]         main_d, main_q;
    logic [W-1:0]         skid_d, skid_q;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH:0]   cnt_sum;
    logic [1:0]           held;
    logic                 accept, emit;
    logic [W-1:0]         in_bundle;
    logic [W-1:0]         bubble_bundle;

    assign in_bundle     = {in_ctrl, in_data};
    // Draining or flushing keeps the stale data and only forces a NOP control.
    assign bubble_bundle = {BUBBLE_CTRL, main_q[DATA_WIDTH-1:0]};

    // Only combinational input-to-output path: stall into in_ready.
    assign in_ready  = (state_q != ST_SKID) && !stall;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_ctrl  = main_q[W-1 -: CTRL_WIDTH];
    assign out_data  = main_q[DATA_WIDTH-1:0];
    assign flush_cnt = cnt_q;

    assign accept = in_valid && in_ready;
    assign emit   = out_valid && out_ready && !stall;

    // Number of valid instructions discarded if a flush lands this cycle.
    always_comb begin
        held = 2'd0;
        case (state_q)
            ST_FULL: held = 2'd1;
            ST_SKID: held = 2'd2;
            default: held = 2'd0;
        endcase
    end

    assign cnt_sum = {1'b0, cnt_q} + {{(CNT_WIDTH - 1){1'b0}}, held};

    // Next state, slot loads and flush accounting; flush overrides everything.
    always_comb begin
        state_d = state_q;
        main_en = 1'b0;
        main_d  = bubble_bundle;
        skid_en = 1'b0;
        skid_d  = in_bundle;
        cnt_d   = cnt_q;

        if (flush) begin
            state_d = ST_EMPTY;
            main_en = 1'b1;
            main_d  = bubble_bundle;
            cnt_d   = cnt_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : cnt_sum[CNT_WIDTH-1:0];
        end else if (!stall) begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_FULL;
                        main_en = 1'b1;
                        main_d  = in_bundle;
                    end
                end
                ST_FULL: begin
                    if (accept && emit) begin
                        main_en = 1'b1;
                        main_d  = in_bundle;
                    end else if (accept) begin
                        state_d = ST_SKID;
                        skid_en = 1'b1;
                    end else if (emit) begin
                        state_d = ST_EMPTY;
                        main_en = 1'b1;
                        main_d  = bubble_bundle;
                    end
                end
                ST_SKID: begin
                    // in_ready is low here, so only the drain side can move.
                    if (emit) begin
                        state_d = ST_FULL;
                        main_en = 1'b1;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_en = 1'b1;
                    main_d  = bubble_bundle;
                end
            endcase
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Saturating flushed-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    pipe_slot_reg #(
        .W       (W),
        .RST_VAL ({BUBBLE_CTRL, {DATA_WIDTH{1'b0}}})
    ) u_main_slot (
        .clk   (clk),
        .reset (reset),
        .en    (main_en),
        .d     (main_d),
        .q     (main_q)
    );

    pipe_slot_reg #(
        .W       (W),
        .RST_VAL ({W{1'b0}})
    ) u_skid_slot (
        .clk   (clk),
        .reset (reset),
        .en    (skid_en),
        .d     (skid_d),
        .q     (skid_q)
    );

endmodule
